// File: rtl/imem_fill_server_pkg.sv
// Shared fill-protocol constants for the instruction cache and its memory-side server.
// The cache and the server both import this package, so they always agree on the line geometry.
package imem_fill_server_pkg;

    localparam int DEFAULT_DATABITWIDTH = 16;
    localparam int DEFAULT_ADDRESSWIDTH = 10;

    localparam int LINES     = 4;
    localparam int LINESIZE  = 8;
    localparam int IDXWIDTH  = $clog2(LINES);
    localparam int OFFSWIDTH = $clog2(LINESIZE);

    typedef logic [IDXWIDTH-1:0] line_idx_t;

endpackage

// File: rtl/imem_fill_server_if.sv
// Bus between the cache/loader side (master) and the program memory fill server (slave).
interface imem_fill_server_if
    import imem_fill_server_pkg::*;
#(
    parameter int DATABITWIDTH = DEFAULT_DATABITWIDTH,
    parameter int ADDRESSWIDTH = DEFAULT_ADDRESSWIDTH
);

    logic [ADDRESSWIDTH-1:0] fill_addr;
    logic [DATABITWIDTH-1:0] fill_data;
    logic                    cache_busy;
    logic                    wr_en;
    logic [ADDRESSWIDTH-1:0] wr_addr;
    logic [DATABITWIDTH-1:0] wr_data;
    logic                    inv;
    line_idx_t               inv_idx;
    logic                    flush_busy;

    modport master (
        output fill_addr, cache_busy, wr_en, wr_addr, wr_data,
        input  fill_data, inv, inv_idx, flush_busy
    );

    modport slave (
        input  fill_addr, cache_busy, wr_en, wr_addr, wr_data,
        output fill_data, inv, inv_idx, flush_busy
    );

endinterface

// File: rtl/imem_fill_server_prio_enc_lsb.sv
// Lowest-set-bit priority encoder; picks which pending line is invalidated next.
module prio_enc_lsb #(
    parameter int WIDTH = 4,
    parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        idx   = '0;
        valid = |vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/imem_fill_server.sv
// Program memory responder for instruction cache line fills. Serves fill reads with one
// cycle of latency and turns program writes into per-line invalidations, holding them back
// while the cache is busy so a tag update cannot overwrite an invalidation.
module imem_fill_server
    import imem_fill_server_pkg::*;
#(
    parameter int DATABITWIDTH = DEFAULT_DATABITWIDTH,
    parameter int ADDRESSWIDTH = DEFAULT_ADDRESSWIDTH
) (
    input logic               clk,
    input logic               sync_rst,
    input logic               clk_en,
    imem_fill_server_if.slave bus
);

    localparam int DEPTH = 2 ** ADDRESSWIDTH;

    logic [DATABITWIDTH-1:0] mem [DEPTH];

    line_idx_t        wr_line;
    line_idx_t        drain_idx;
    logic             drain_valid;
    logic [LINES-1:0] pending;
    logic [LINES-1:0] wr_mask;
    logic [LINES-1:0] cand;
    logic [LINES-1:0] drain_mask;

    assign wr_line = bus.wr_addr[IDXWIDTH+OFFSWIDTH-1:OFFSWIDTH];

    // Merge this cycle's write into the pending set and build a mask for the line being drained.
    always_comb begin
        wr_mask    = '0;
        drain_mask = '0;
        if (bus.wr_en) begin
            wr_mask[wr_line] = 1'b1;
        end
        cand                  = pending | wr_mask;
        drain_mask[drain_idx] = 1'b1;
    end

    prio_enc_lsb #(
        .WIDTH (LINES),
        .IDXW  (IDXWIDTH)
    ) u_drain_sel (
        .vec   (cand),
        .idx   (drain_idx),
        .valid (drain_valid)
    );

    // Program memory writes; contents survive reset, so only the clock enable gates them.
    always_ff @(posedge clk) begin
        if (clk_en && bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Registered fill read; the old word is returned when a write hits the same address.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (!sync_rst) begin
                bus.fill_data <= '0;
            end else begin
                bus.fill_data <= mem[bus.fill_addr];
            end
        end
    end

    // Issue at most one invalidation per cycle, lowest line first, only while the cache is idle.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (!sync_rst) begin
                pending     <= '0;
                bus.inv     <= 1'b0;
                bus.inv_idx <= '0;
            end else if (!bus.cache_busy && drain_valid) begin
                pending     <= cand & ~drain_mask;
                bus.inv     <= 1'b1;
                bus.inv_idx <= drain_idx;
            end else begin
                pending     <= cand;
                bus.inv     <= 1'b0;
            end
        end
    end

    assign bus.flush_busy = (|pending) | bus.inv;

endmodule

// File: tb/tb_imem_fill_server.sv
// Bench for imem_fill_server: directed vector table for the fill, invalidate, reset and
// enable scenarios, followed by randomized traffic checked against a behavioural model.
module tb_imem_fill_server;
    import imem_fill_server_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic sync_rst;
    logic clk_en;

    int total = 0;
    int bad   = 0;

    imem_fill_server_if #(.DATABITWIDTH(DW), .ADDRESSWIDTH(AW)) bus ();

    imem_fill_server #(.DATABITWIDTH(DW), .ADDRESSWIDTH(AW)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .clk_en   (clk_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state: plain memory image plus a set of lines awaiting invalidation.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    logic [DW-1:0] m_data;
    bit            m_data_ok;
    bit            m_inv;
    int            m_idx;
    bit            m_pend  [LINES];

    typedef struct {
        bit            rst_n;
        bit            en;
        bit            busy;
        bit            we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] fa;
        bit            chk_data;
        logic [DW-1:0] exp_data;
        bit            exp_inv;
        int            exp_idx;
        bit            exp_flush;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One enabled or disabled clock of the model, evaluated from the inputs seen at the edge.
    task automatic model_step(input bit rst_n, input bit en, input bit busy, input bit we,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic [AW-1:0] fa);
        bit cand [LINES];
        int low;
        if (!en) return;
        if (!rst_n) begin
            m_data    = '0;
            m_data_ok = 1'b1;
            m_inv     = 1'b0;
            m_idx     = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else begin
            m_data    = m_mem[fa];
            m_data_ok = m_known[fa];
            foreach (cand[i]) cand[i] = m_pend[i];
            if (we) cand[(int'(wa) / LINESIZE) % LINES] = 1'b1;
            low = -1;
            for (int i = 0; i < LINES; i++) begin
                if (cand[i] && low < 0) low = i;
            end
            if (!busy && low >= 0) begin
                m_inv     = 1'b1;
                m_idx     = low;
                cand[low] = 1'b0;
            end else begin
                m_inv = 1'b0;
            end
            foreach (m_pend[i]) m_pend[i] = cand[i];
        end
        if (we) begin
            m_mem[wa]   = wd;
            m_known[wa] = 1'b1;
        end
    endtask

    function automatic bit model_flush();
        bit any = m_inv;
        foreach (m_pend[i]) any |= m_pend[i];
        return any;
    endfunction

    // Drive one cycle of inputs, clock it, then compare every output with the model.
    task automatic apply_stimulus(input bit rst_n, input bit en, input bit busy, input bit we,
                                  input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                  input logic [AW-1:0] fa);
        sync_rst       = rst_n;
        clk_en         = en;
        bus.cache_busy = busy;
        bus.wr_en      = we;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.fill_addr  = fa;
        @(posedge clk);
        model_step(rst_n, en, busy, we, wa, wd, fa);
        #1;
        if (m_data_ok) check("mdl_fill_data", 32'(bus.fill_data), 32'(m_data));
        check("mdl_inv", 32'(bus.inv), 32'(m_inv));
        check("mdl_inv_idx", 32'(bus.inv_idx), 32'(m_idx));
        check("mdl_flush_busy", 32'(bus.flush_busy), 32'(model_flush()));
    endtask

    function automatic void add(input bit rst_n, input bit en, input bit busy, input bit we,
                                input int wa, input int wd, input int fa,
                                input bit chk_data, input int exp_data,
                                input bit exp_inv, input int exp_idx, input bit exp_flush);
        vec_t v;
        v.rst_n     = rst_n;
        v.en        = en;
        v.busy      = busy;
        v.we        = we;
        v.wa        = AW'(wa);
        v.wd        = DW'(wd);
        v.fa        = AW'(fa);
        v.chk_data  = chk_data;
        v.exp_data  = DW'(exp_data);
        v.exp_inv   = exp_inv;
        v.exp_idx   = exp_idx;
        v.exp_flush = exp_flush;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input int n, input vec_t v);
        if (v.chk_data) check($sformatf("tbl%0d_fill_data", n), 32'(bus.fill_data), 32'(v.exp_data));
        check($sformatf("tbl%0d_inv", n), 32'(bus.inv), 32'(v.exp_inv));
        if (v.exp_inv) check($sformatf("tbl%0d_inv_idx", n), 32'(bus.inv_idx), v.exp_idx);
        check($sformatf("tbl%0d_flush_busy", n), 32'(bus.flush_busy), 32'(v.exp_flush));
    endtask

    initial begin
        bit            busy_r;
        bit            rst_n;
        bit            we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;

        foreach (m_known[i]) m_known[i] = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_data    = '0;
        m_data_ok = 1'b0;
        m_inv     = 1'b0;
        m_idx     = 0;

        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        check("reset_fill_data", 32'(bus.fill_data), 32'h0);
        check("reset_inv", 32'(bus.inv), 32'h0);
        check("reset_flush_busy", 32'(bus.flush_busy), 32'h0);

        // Load the whole memory with the cache idle; each write invalidates its own line.
        for (int a = 0; a < DEPTH; a++) begin
            if (a >= 'h040 && a <= 'h047) wd = DW'('h1000 + a - 'h040);
            else if (a == 'h020) wd = 16'hAAAA;
            else wd = DW'($urandom);
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, AW'(a), wd, AW'((a == 0) ? 0 : a - 1));
        end
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);

        // rst_n en busy we  wa     wd      fa     chk data     inv idx flush
        for (int i = 0; i < 8; i++)
            add(1, 1, 0, 0, 0, 0, 'h040 + i, 1, 'h1000 + i, 0, 0, 0);
        add(1, 1, 0, 1, 'h05A, 'hBEEF, 'h000, 0, 0,       1, 3, 1);
        add(1, 1, 0, 0, 0,     0,      'h05A, 1, 'hBEEF,  0, 0, 0);
        add(1, 1, 1, 1, 'h010, 'h0111, 'h000, 0, 0,       0, 0, 1);
        add(1, 1, 1, 1, 'h008, 'h0222, 'h000, 0, 0,       0, 0, 1);
        for (int i = 0; i < 5; i++)
            add(1, 1, 1, 0, 0, 0, 'h000, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0,     0,      'h000, 0, 0,       1, 1, 1);
        add(1, 1, 0, 0, 0,     0,      'h000, 0, 0,       1, 2, 1);
        add(1, 1, 0, 0, 0,     0,      'h010, 1, 'h0111,  0, 0, 0);
        add(1, 1, 1, 1, 'h018, 'h0333, 'h000, 0, 0,       0, 0, 1);
        add(1, 1, 1, 1, 'h01F, 'h0444, 'h000, 0, 0,       0, 0, 1);
        add(1, 1, 0, 0, 0,     0,      'h000, 0, 0,       1, 3, 1);
        add(1, 1, 0, 0, 0,     0,      'h01F, 1, 'h0444,  0, 0, 0);
        add(1, 1, 0, 1, 'h020, 'h5555, 'h020, 1, 'hAAAA,  1, 0, 1);
        add(1, 1, 0, 0, 0,     0,      'h020, 1, 'h5555,  0, 0, 0);
        add(1, 1, 1, 1, 'h000, 'h0555, 'h000, 0, 0,       0, 0, 1);
        add(1, 1, 1, 1, 'h008, 'h0666, 'h000, 0, 0,       0, 0, 1);
        add(1, 1, 1, 1, 'h018, 'h0777, 'h000, 0, 0,       0, 0, 1);
        add(0, 1, 1, 0, 0,     0,      'h020, 1, 'h0000,  0, 0, 0);
        add(1, 1, 0, 0, 0,     0,      'h020, 1, 'h5555,  0, 0, 0);
        add(1, 1, 0, 0, 0,     0,      'h05A, 1, 'hBEEF,  0, 0, 0);
        add(1, 1, 1, 1, 'h030, 'h0888, 'h05A, 1, 'hBEEF,  0, 0, 1);
        add(1, 0, 0, 1, 'h05A, 'h1234, 'h020, 1, 'hBEEF,  0, 0, 1);
        add(1, 1, 0, 0, 0,     0,      'h05A, 1, 'hBEEF,  1, 2, 1);
        add(1, 1, 0, 0, 0,     0,      'h000, 0, 0,       0, 0, 0);

        foreach (vecs[n]) begin
            apply_stimulus(vecs[n].rst_n, vecs[n].en, vecs[n].busy, vecs[n].we,
                           vecs[n].wa, vecs[n].wd, vecs[n].fa);
            check_output(n, vecs[n]);
        end

        // Random traffic: busy comes in runs, writes favour the low lines to provoke merges.
        busy_r = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) busy_r = ~busy_r;
            rst_n = ($urandom_range(0, 59) != 0);
            we    = rst_n ? 1'($urandom_range(0, 1)) : 1'b0;
            wa    = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom);
            wd    = DW'($urandom);
            apply_stimulus(rst_n, ($urandom_range(0, 7) != 0), busy_r, we, wa, wd,
                           AW'($urandom_range(0, 63)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
